// File: rtl/nw_tile_scheduler.sv
// rtl/nw_tile_scheduler.sv - row-major tile sequencer for a blocked Needleman-Wunsch Grid
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   start, dna_length   job request; length sampled with start in IDLE
//   busy                job in progress (ISSUE through DONE)
//   tile_valid          one-cycle pulse: Grid loads tile_row/tile_col
//   tile_row, tile_col  current tile indices, stable from tile_valid to capture
//   first_row/first_col current tile lies on the top row / left column
//   top_base, left_base edge base scores for first-row / first-column tiles
//   capture             one-cycle pulse: write Grid edge outputs to boundary buffers
//   result_valid        final tile result ready, held until result_ack
//   result_ack          consumer accepts the result
//   error               one-cycle pulse on a rejected start
module nw_tile_scheduler #(
   parameter int INT_WIDTH    = 32,
   parameter int CHUNK_LENGTH = 10,
   parameter int MAX_CHUNKS   = 16,
   parameter int IDX_WIDTH    = 4,
   parameter int GRID_LATENCY = 40,
   parameter int LAT_WIDTH    = 8,
   parameter int SWIDTH       = 16,
   parameter int INDEL        = -1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [INT_WIDTH-1:0]     dna_length,
   output logic                     busy,
   output logic                     tile_valid,
   output logic [IDX_WIDTH-1:0]     tile_row,
   output logic [IDX_WIDTH-1:0]     tile_col,
   output logic                     first_row,
   output logic                     first_col,
   output logic signed [SWIDTH-1:0] top_base,
   output logic signed [SWIDTH-1:0] left_base,
   output logic                     capture,
   output logic                     result_valid,
   input  logic                     result_ack,
   output logic                     error
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_t;

   localparam logic [INT_WIDTH-1:0]     MAX_LEN   = INT_WIDTH'(MAX_CHUNKS * CHUNK_LENGTH);
   localparam logic [INT_WIDTH-1:0]     CL_W      = INT_WIDTH'(CHUNK_LENGTH);
   localparam logic signed [SWIDTH-1:0] BASE_STEP = SWIDTH'(INDEL * CHUNK_LENGTH);
   localparam logic [LAT_WIDTH-1:0]     LAT_LOAD  = LAT_WIDTH'(GRID_LATENCY - 1);

   state_t                     state_q, state_d;
   logic [IDX_WIDTH-1:0]       last_q, last_d;    // nchunks-1, the index of the final row/column
   logic [IDX_WIDTH-1:0]       row_q, row_d;
   logic [IDX_WIDTH-1:0]       col_q, col_d;
   logic signed [SWIDTH-1:0]   top_q, top_d;
   logic signed [SWIDTH-1:0]   left_q, left_d;
   logic [LAT_WIDTH-1:0]       lat_q, lat_d;
   logic                       err_q, err_d;

   logic start_ok;
   logic at_last_col;
   logic at_last_row;

   // Length 1..MAX_CHUNKS*CHUNK_LENGTH is exactly nchunks in 1..MAX_CHUNKS.
   assign start_ok    = (dna_length != '0) && (dna_length <= MAX_LEN);
   assign at_last_col = (col_q == last_q);
   assign at_last_row = (row_q == last_q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         last_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         top_q   <= '0;
         left_q  <= '0;
         lat_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         row_q   <= row_d;
         col_q   <= col_d;
         top_q   <= top_d;
         left_q  <= left_d;
         lat_q   <= lat_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start && start_ok) state_d = S_ISSUE;
         S_ISSUE:   state_d = S_WAIT;
         S_WAIT:    if (lat_q == '0) state_d = S_CAPTURE;
         S_CAPTURE: state_d = (at_last_col && at_last_row) ? S_DONE : S_ISSUE;
         S_DONE:    if (result_ack) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      last_d = last_q;
      row_d  = row_q;
      col_d  = col_q;
      top_d  = top_q;
      left_d = left_q;
      lat_d  = lat_q;
      err_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (start_ok) begin
                  // ceil(n/C)-1 == floor((n-1)/C) for n >= 1
                  last_d = IDX_WIDTH'((dna_length - INT_WIDTH'(1)) / CL_W);
                  row_d  = '0;
                  col_d  = '0;
                  top_d  = '0;
                  left_d = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_ISSUE: lat_d = LAT_LOAD;
         S_WAIT:  if (lat_q != '0) lat_d = lat_q - LAT_WIDTH'(1);
         S_CAPTURE: begin
            // Bases are accumulated one step per tile; they wrap modulo 2^SWIDTH.
            if (at_last_col && !at_last_row) begin
               col_d  = '0;
               top_d  = '0;
               row_d  = row_q + IDX_WIDTH'(1);
               left_d = left_q + BASE_STEP;
            end else if (!at_last_col) begin
               col_d = col_q + IDX_WIDTH'(1);
               top_d = top_q + BASE_STEP;
            end
         end
         default: ;
      endcase
   end

   assign busy         = (state_q != S_IDLE);
   assign tile_valid   = (state_q == S_ISSUE);
   assign capture      = (state_q == S_CAPTURE);
   assign result_valid = (state_q == S_DONE);
   assign error        = err_q;
   assign tile_row     = row_q;
   assign tile_col     = col_q;
   assign first_row    = (row_q == '0);
   assign first_col    = (col_q == '0);
   assign top_base     = top_q;
   assign left_base    = left_q;

endmodule
